// File: rtl/cpu_prefetch_pkg.sv
// cpu_prefetch_pkg
//   Shared types and constants for the instruction prefetch unit.
//   - VIRTUAL_ADDR_WIDTH : default fetch/PC address width
//   - BOOT_ADDR          : first fetch address after reset
//   - EXCEPTION_ADDR     : fetch target of an exception redirect
//   - fetch_state_t      : prefetch FSM states (RUN / FAULT)
//   - occ_width()        : width of an occupancy counter for a given depth
package cpu_prefetch_pkg;

    localparam int VIRTUAL_ADDR_WIDTH = 32;

    localparam logic [31:0] BOOT_ADDR      = 32'h0000_0100;
    localparam logic [31:0] EXCEPTION_ADDR = 32'h0000_0080;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_t;

    // Counter must hold the value DEPTH itself, hence one bit above the pointer width.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cpu_prefetch_if.sv
// cpu_prefetch_if
//   Bundles the redirect, TLB, icache and decode-side signals of the prefetch unit.
//   - master : prefetch unit view (drives cache request, queue head, fault, occupancy)
//   - slave  : environment view (drives redirect, TLB status, cache response, out_ready)
interface cpu_prefetch_if
    import cpu_prefetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = VIRTUAL_ADDR_WIDTH,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
);
    localparam int CNT_W = occ_width(DEPTH);

    logic                   redirect_valid;
    logic                   redirect_exception;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic                   tlb_enable;
    logic                   tlb_hit;
    logic                   cache_req_valid;
    logic [ADDR_WIDTH-1:0]  cache_req_pc;
    logic                   cache_resp_hit;
    logic [INSTR_WIDTH-1:0] cache_resp_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0]  out_pc;
    logic                   fault_valid;
    logic [ADDR_WIDTH-1:0]  fault_pc;
    logic [CNT_W-1:0]       occupancy;

    modport master (
        input  redirect_valid, redirect_exception, redirect_pc,
        input  tlb_enable, tlb_hit,
        input  cache_resp_hit, cache_resp_data,
        input  out_ready,
        output cache_req_valid, cache_req_pc,
        output out_valid, out_instr, out_pc,
        output fault_valid, fault_pc, occupancy
    );

    modport slave (
        output redirect_valid, redirect_exception, redirect_pc,
        output tlb_enable, tlb_hit,
        output cache_resp_hit, cache_resp_data,
        output out_ready,
        input  cache_req_valid, cache_req_pc,
        input  out_valid, out_instr, out_pc,
        input  fault_valid, fault_pc, occupancy
    );

endinterface

// File: rtl/cpu_prefetch_fifo.sv
// cpu_prefetch_fifo
//   Synchronous FIFO with flush; head is read combinationally from storage.
//   clock/reset : rising-edge clock, synchronous active-low reset
//   flush       : empties the queue (pointers and count to zero), overrides push/pop
//   push/wdata  : write at tail (caller guarantees not full)
//   pop         : advance head (caller guarantees not empty)
//   rdata       : entry at head
//   count       : number of entries held, 0..DEPTH
module cpu_prefetch_fifo
    import cpu_prefetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WIDTH-1:0]            wdata,
    input  logic                        pop,
    output logic [WIDTH-1:0]            rdata,
    output logic [occ_width(DEPTH)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = occ_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Next pointer/count values; power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1'b1);
                2'b01:   count_d = count_q - CNT_W'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/cpu_prefetch.sv
// cpu_prefetch
//   Sequential instruction prefetcher feeding a small queue to decode.
//   clock/reset : rising-edge clock, synchronous active-low reset
//   bus.master  : redirect/TLB/icache inputs, queue head, fault report, occupancy
//   Fetch stalls on a full queue or icache miss, halts in FAULT on a TLB miss,
//   and a redirect flushes the queue and restarts fetch at the new target.
module cpu_prefetch
    import cpu_prefetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = VIRTUAL_ADDR_WIDTH,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4,
    parameter int PC_STEP     = 4
) (
    input  logic          clock,
    input  logic          reset,
    cpu_prefetch_if.master bus
);
    localparam int CNT_W   = occ_width(DEPTH);
    localparam int ENTRY_W = ADDR_WIDTH + INSTR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] BOOT_PC  = ADDR_WIDTH'(BOOT_ADDR);
    localparam logic [ADDR_WIDTH-1:0] EXC_PC   = ADDR_WIDTH'(EXCEPTION_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(PC_STEP);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(2'b11);
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;

    logic [CNT_W-1:0]   count_s;
    logic [ENTRY_W-1:0] head_s;
    logic               slot_free_s;
    logic               xlate_ok_s;
    logic               req_s;
    logic               push_s;
    logic               out_valid_s;
    logic               pop_s;

    cpu_prefetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (bus.redirect_valid),
        .push  (push_s),
        .wdata ({fetch_pc_q, bus.cache_resp_data}),
        .pop   (pop_s),
        .rdata (head_s),
        .count (count_s)
    );

    // Request / push / pop qualification; reset and redirect silence both sides.
    always_comb begin
        slot_free_s = (count_s != FULL_CNT);
        xlate_ok_s  = bus.tlb_hit || !bus.tlb_enable;
        req_s       = reset && (state_q == ST_RUN) && slot_free_s &&
                      !bus.redirect_valid && xlate_ok_s;
        push_s      = req_s && bus.cache_resp_hit;
        out_valid_s = reset && (count_s != {CNT_W{1'b0}}) && !bus.redirect_valid;
        pop_s       = out_valid_s && bus.out_ready;
    end

    // FSM and fetch_pc next state; redirect outranks fault detection and advance.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) begin
            state_d    = ST_RUN;
            fetch_pc_d = bus.redirect_exception ? EXC_PC : (bus.redirect_pc & ALIGN_MASK);
        end else begin
            case (state_q)
                ST_RUN: begin
                    // A TLB miss only counts when a request would otherwise have gone out.
                    if (bus.tlb_enable && !bus.tlb_hit && slot_free_s) begin
                        state_d = ST_FAULT;
                    end else if (push_s) begin
                        fetch_pc_d = fetch_pc_q + STEP;
                    end else begin
                        fetch_pc_d = fetch_pc_q;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // FSM state and fetch address registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= BOOT_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign bus.cache_req_valid = req_s;
    assign bus.cache_req_pc    = fetch_pc_q;
    assign bus.out_valid       = out_valid_s;
    assign bus.out_pc          = head_s[ENTRY_W-1:INSTR_WIDTH];
    assign bus.out_instr       = head_s[INSTR_WIDTH-1:0];
    assign bus.fault_valid     = reset && (state_q == ST_FAULT);
    assign bus.fault_pc        = fetch_pc_q;
    assign bus.occupancy       = reset ? count_s : {CNT_W{1'b0}};

endmodule

// File: doc/cpu_prefetch.md
CPU_PREFETCH -- requirements
Module: CPU_prefetch

Interface
REQ-001 Parameter ADDR_WIDTH, default `VIRTUAL_ADDR_WIDTH, fetch/PC address width.
REQ-002 Parameter INSTR_WIDTH, default 32, instruction word width.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-004 Parameter PC_STEP, default 4, sequential PC increment.
REQ-005 clock  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 redirect_valid  in  1  jump or exception this cycle.
REQ-008 redirect_exception  in  1  redirect targets `EXCEPTION_ADDR when set.
REQ-009 redirect_pc  in  ADDR_WIDTH  jump target.
REQ-010 tlb_enable  in  1  translation active.
REQ-011 tlb_hit  in  1  translation of cache_req_pc valid this cycle.
REQ-012 cache_req_valid  out  1  icache read request.
REQ-013 cache_req_pc  out  ADDR_WIDTH  address of the request.
REQ-014 cache_resp_hit  in  1  same-cycle icache hit for cache_req_pc.
REQ-015 cache_resp_data  in  INSTR_WIDTH  instruction on hit.
REQ-016 out_valid  out  1  queue head valid to decode.
REQ-017 out_ready  in  1  decode accepts head.
REQ-018 out_instr  out  INSTR_WIDTH  head instruction.
REQ-019 out_pc  out  ADDR_WIDTH  head PC.
REQ-020 fault_valid  out  1  fetch halted on TLB miss.
REQ-021 fault_pc  out  ADDR_WIDTH  PC that missed.
REQ-022 occupancy  out  $clog2(DEPTH)+1  entries held.

Function
REQ-023 FSM states RUN and FAULT; state and fetch_pc registered.
REQ-024 cache_req_pc shall equal fetch_pc; cache_req_valid = RUN && occupancy<DEPTH && !redirect_valid && (tlb_hit || !tlb_enable).
REQ-025 Push when cache_req_valid && cache_resp_hit: write {fetch_pc, cache_resp_data} at tail; fetch_pc += PC_STEP, wrapping modulo 2^ADDR_WIDTH.
REQ-026 Cache miss (request without hit): fetch_pc held, request repeats next cycle; no push.
REQ-027 RUN && tlb_enable && !tlb_hit && occupancy<DEPTH && !redirect_valid: next state FAULT; fetch_pc held.
REQ-028 In FAULT: fault_valid=1, fault_pc=fetch_pc, no requests; queue still drains via out_ready.
REQ-029 out_valid = occupancy!=0 && !redirect_valid; pop when out_valid && out_ready.
REQ-030 Latency: instruction pushed cycle N appears at head no earlier than N+1; no empty bypass.
REQ-031 Push and pop same cycle: occupancy unchanged, both pointers advance.
REQ-032 Full (occupancy==DEPTH): no request, fetch_pc held; pop frees a slot usable next cycle.
REQ-033 Pointers $clog2(DEPTH) bits, wrap DEPTH-1 -> 0.
REQ-034 redirect_valid has priority over all: occupancy, pointers cleared; no push, no pop; state -> RUN; fetch_pc <= redirect_exception ? `EXCEPTION_ADDR : {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
REQ-035 Redirect in FAULT: leaves FAULT next cycle, fault_valid low next cycle.

Reset
REQ-036 reset low at an edge: fetch_pc=`BOOT_ADDR, state RUN, pointers and occupancy 0, queue contents don't-care.
REQ-037 During reset: out_valid=0, cache_req_valid=0, fault_valid=0, occupancy=0; overrides redirect, hit and pop in progress.
REQ-038 First request issued the cycle after reset deasserts, at `BOOT_ADDR.

Structure
REQ-039 FSM state enum fetch_state_t in CPU_types.vh; `BOOT_ADDR, `EXCEPTION_ADDR from CPU_define.vh.
REQ-040 Queue storage in sub-module CPU_fifo (synchronous FIFO, parameters WIDTH, DEPTH, flush input); CPU_prefetch holds FSM and fetch_pc.

Verification
REQ-041 Reset, always hit, out_ready=1, tlb_enable=0 -> out_pc `BOOT_ADDR, +4, +8 on consecutive cycles from cycle 2.
REQ-042 out_ready=0, DEPTH=4, always hit -> occupancy 4, cache_req_valid=0, fetch_pc=BOOT+16; one pop -> request resumes next cycle.
REQ-043 cache_resp_hit low 3 cycles at 0x100 -> cache_req_pc stays 0x100; no push; then 0x100 pushed once.
REQ-044 Queue holding 3 entries, redirect_valid with redirect_pc=0x2003 -> occupancy 0, out_valid 0 next cycle, next request 0x2000.
REQ-045 tlb_enable=1, tlb_hit=0 at 0x400 -> fault_valid=1, fault_pc=0x400, queue drains; redirect_exception -> fetch at `EXCEPTION_ADDR, fault_valid 0.
REQ-046 fetch_pc at 2^ADDR_WIDTH-4 with hit -> next cache_req_pc 0.
